// File: rtl/fsmc_frontend_if.sv
// FSMC pin-side and back-end request/response signals of the FSMC front end.
// The slave modport is the front end's view; master is the bus/back-end side.
interface fsmc_frontend_if #(
  parameter int AW = 2,
  parameter int DW = 16
);
  logic          nce;
  logic          noe;
  logic          nwe;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic          wr_stb;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_stb;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          err_pulse;
  logic [7:0]    err_cnt;
  logic          busy;

  modport slave (
    input  nce, noe, nwe, addr, data_in, rd_data, rd_valid,
    output data_out, data_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr,
           err_pulse, err_cnt, busy
  );

  modport master (
    output nce, noe, nwe, addr, data_in, rd_data, rd_valid,
    input  data_out, data_oe, wr_stb, wr_addr, wr_data, rd_stb, rd_addr,
           err_pulse, err_cnt, busy
  );
endinterface

// File: rtl/fsmc_frontend.sv
// FSMC slave front end: synchronises async strobes, aligns addr/data with them,
// and turns bus cycles into single-cycle read/write requests plus error tracking.
module fsmc_frontend #(
  parameter int AW   = 2,
  parameter int DW   = 16,
  parameter int SYNC = 2,
  parameter int FILT = 1
) (
  input  logic           clk,
  input  logic           rst,
  fsmc_frontend_if.slave bus
);
  localparam int FW = $clog2(FILT + 1);
  localparam int CW = $clog2(SYNC + 1);

  typedef enum logic [2:0] {IDLE, WR_ACTIVE, RD_WAIT, RD_DRIVE, ABORT} state_t;

  state_t                  state_q, state_d;
  logic [SYNC-1:0]         nce_q, noe_q, nwe_q;
  logic [SYNC-1:0][AW-1:0] addr_q;
  logic [SYNC-1:0][DW-1:0] din_q;
  logic [FW-1:0]           oe_flt_q, we_flt_q;
  logic [CW-1:0]           flush_q;
  logic                    armed_q;
  logic [DW-1:0]           data_out_q, data_out_d;
  logic [7:0]              err_cnt_q;

  logic nce_s, noe_s, nwe_s, sel, oe_acc, we_acc, flush_done;
  logic wr_stb, rd_stb, err, oe;

  assign nce_s      = nce_q[SYNC-1];
  assign noe_s      = noe_q[SYNC-1];
  assign nwe_s      = nwe_q[SYNC-1];
  assign sel        = ~nce_s;
  assign oe_acc     = ~noe_s && (oe_flt_q >= FW'(FILT - 1));
  assign we_acc     = ~nwe_s && (we_flt_q >= FW'(FILT - 1));
  // Synchronisers read all-ones for SYNC cycles after reset; ignore pins until flushed.
  assign flush_done = (flush_q == CW'(SYNC));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      nce_q      <= '1;
      noe_q      <= '1;
      nwe_q      <= '1;
      addr_q     <= '0;
      din_q      <= '0;
      oe_flt_q   <= '0;
      we_flt_q   <= '0;
      flush_q    <= '0;
      armed_q    <= 1'b0;
      data_out_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      nce_q      <= {nce_q[SYNC-2:0], bus.nce};
      noe_q      <= {noe_q[SYNC-2:0], bus.noe};
      nwe_q      <= {nwe_q[SYNC-2:0], bus.nwe};
      addr_q     <= {addr_q[SYNC-2:0], bus.addr};
      din_q      <= {din_q[SYNC-2:0], bus.data_in};
      if (noe_s) oe_flt_q <= '0;
      else if (oe_flt_q != FW'(FILT)) oe_flt_q <= oe_flt_q + 1'b1;
      if (nwe_s) we_flt_q <= '0;
      else if (we_flt_q != FW'(FILT)) we_flt_q <= we_flt_q + 1'b1;
      if (!flush_done) flush_q <= flush_q + 1'b1;
      armed_q    <= flush_done;
      data_out_q <= data_out_d;
      if (err && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_out_d = data_out_q;
    wr_stb     = 1'b0;
    rd_stb     = 1'b0;
    err        = 1'b0;
    oe         = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_done) begin
          // First look after reset: a cycle already in flight is sat out in ABORT.
          if (!armed_q) begin
            if (~noe_s || ~nwe_s || ~nce_s) state_d = ABORT;
          end else if (sel) begin
            if (oe_acc && we_acc) begin
              state_d = ABORT;
              err     = 1'b1;
            end else if (we_acc) begin
              state_d = WR_ACTIVE;
            end else if (oe_acc) begin
              state_d = RD_WAIT;
              rd_stb  = 1'b1;
            end
          end
        end
      end
      WR_ACTIVE: begin
        if (~noe_s) begin
          state_d = ABORT;
          err     = 1'b1;
        end else if (nwe_s) begin
          state_d = IDLE;
          wr_stb  = 1'b1;
        end else if (nce_s) begin
          state_d = IDLE;
          err     = 1'b1;
        end
      end
      RD_WAIT: begin
        if (noe_s || nce_s) begin
          state_d = IDLE;
          err     = 1'b1;
        end else if (bus.rd_valid) begin
          data_out_d = bus.rd_data;
          state_d    = RD_DRIVE;
        end
      end
      RD_DRIVE: begin
        if (noe_s || nce_s) begin
          state_d = IDLE;
        end else if (~nwe_s) begin
          state_d = ABORT;
          err     = 1'b1;
        end else begin
          oe = 1'b1;
        end
      end
      ABORT: begin
        if (noe_s && nwe_s && nce_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = oe;
  assign bus.wr_stb    = wr_stb;
  assign bus.wr_addr   = wr_stb ? addr_q[SYNC-1] : '0;
  assign bus.wr_data   = wr_stb ? din_q[SYNC-1] : '0;
  assign bus.rd_stb    = rd_stb;
  assign bus.rd_addr   = rd_stb ? addr_q[SYNC-1] : '0;
  assign bus.err_pulse = err;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_fsmc_frontend.sv
// Directed bench for fsmc_frontend (SYNC=2, FILT=2): write, read, late read,
// overlap, glitch, deselect, error saturation and reset during a read.
module tb_fsmc_frontend;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   wr_n = 0, rd_n = 0, oe_n = 0;
  int   oe_base;

  fsmc_frontend_if #(.AW(2), .DW(16)) bus ();

  fsmc_frontend #(.AW(2), .DW(16), .SYNC(2), .FILT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.wr_stb)  wr_n <= wr_n + 1;
    if (!rst && bus.rd_stb)  rd_n <= rd_n + 1;
    if (!rst && bus.data_oe) oe_n <= oe_n + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ovl();
    bus.nce = 1'b0; bus.noe = 1'b0; bus.nwe = 1'b0;
    tick(4);
    bus.noe = 1'b1; bus.nwe = 1'b1; bus.nce = 1'b1;
    tick(4);
  endtask

  initial begin
    rst = 1'b1;
    bus.nce = 1'b1; bus.noe = 1'b1; bus.nwe = 1'b1;
    bus.addr = '0; bus.data_in = '0; bus.rd_data = '0; bus.rd_valid = 1'b0;
    tick(3);
    chk("rst_oe",   bus.data_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cnt",  bus.err_cnt, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_wr",   bus.wr_stb, 0);
    rst = 1'b0;
    tick(5);

    // write: wr_stb lands SYNC+1 edges after nwe rises, with pre-rise data
    bus.nce = 1'b0; bus.addr = 2'b10; bus.data_in = 16'h1234;
    tick(1);
    bus.nwe = 1'b0;
    tick(6);
    chk("wr_busy", bus.busy, 1);
    bus.nwe = 1'b1;
    tick(1);
    chk("wr_early", bus.wr_stb, 0);
    bus.data_in = 16'hDEAD;
    tick(1);
    chk("wr_stb",  bus.wr_stb, 1);
    chk("wr_addr", bus.wr_addr, 2);
    chk("wr_data", bus.wr_data, 16'h1234);
    tick(1);
    chk("wr_idle", bus.busy, 0);
    bus.nce = 1'b1; bus.data_in = '0;
    tick(3);
    chk("wr_count", wr_n, 1);
    chk("wr_noerr", bus.err_cnt, 0);

    // read with rd_valid two clocks after rd_stb
    bus.nce = 1'b0; bus.addr = 2'b01;
    tick(1);
    bus.noe = 1'b0;
    tick(2);
    chk("rd_early", bus.rd_stb, 0);
    tick(1);
    chk("rd_stb",  bus.rd_stb, 1);
    chk("rd_addr", bus.rd_addr, 1);
    tick(2);
    bus.rd_valid = 1'b1; bus.rd_data = 16'hBEEF;
    tick(1);
    bus.rd_valid = 1'b0; bus.rd_data = '0;
    chk("rd_oe",   bus.data_oe, 1);
    chk("rd_dout", bus.data_out, 16'hBEEF);
    tick(2);
    bus.noe = 1'b1;
    tick(1);
    chk("rd_oe_hold", bus.data_oe, 1);
    tick(1);
    chk("rd_oe_off", bus.data_oe, 0);
    tick(1);
    chk("rd_idle",  bus.busy, 0);
    chk("rd_count", rd_n, 1);
    bus.nce = 1'b1;
    tick(3);

    // late read: noe rises before rd_valid
    oe_base = oe_n;
    bus.nce = 1'b0; bus.addr = 2'b11;
    tick(1);
    bus.noe = 1'b0;
    tick(3);
    bus.noe = 1'b1;
    tick(2);
    chk("late_pulse", bus.err_pulse, 1);
    tick(1);
    chk("late_pulse_off", bus.err_pulse, 0);
    chk("late_cnt", bus.err_cnt, 1);
    tick(1);
    bus.rd_valid = 1'b1; bus.rd_data = 16'h1111;
    tick(1);
    bus.rd_valid = 1'b0; bus.rd_data = '0;
    tick(2);
    chk("late_dout", bus.data_out, 16'hBEEF);
    chk("late_no_oe", oe_n, oe_base);
    chk("late_rdcnt", rd_n, 2);
    bus.nce = 1'b1;
    tick(3);

    // overlap of noe and nwe
    bus.nce = 1'b0;
    tick(1);
    bus.noe = 1'b0; bus.nwe = 1'b0;
    tick(3);
    chk("ovl_pulse", bus.err_pulse, 1);
    tick(1);
    chk("ovl_busy", bus.busy, 1);
    chk("ovl_cnt",  bus.err_cnt, 2);
    bus.noe = 1'b1; bus.nwe = 1'b1;
    tick(4);
    chk("ovl_hold", bus.busy, 1);
    bus.nce = 1'b1;
    tick(4);
    chk("ovl_idle", bus.busy, 0);
    chk("ovl_wr", wr_n, 1);
    chk("ovl_rd", rd_n, 2);

    // one-clock noe glitch is filtered out
    bus.nce = 1'b0;
    tick(2);
    bus.noe = 1'b0;
    tick(1);
    bus.noe = 1'b1;
    tick(5);
    chk("glitch_rd",   rd_n, 2);
    chk("glitch_busy", bus.busy, 0);
    bus.nce = 1'b1;
    tick(3);

    // full write while deselected
    bus.nwe = 1'b0;
    tick(6);
    bus.nwe = 1'b1;
    tick(4);
    chk("desel_wr",   wr_n, 1);
    chk("desel_err",  bus.err_cnt, 2);
    chk("desel_busy", bus.busy, 0);

    // saturation
    for (int i = 0; i < 252; i++) ovl();
    chk("sat_254", bus.err_cnt, 254);
    for (int i = 0; i < 48; i++) ovl();
    chk("sat_255",  bus.err_cnt, 255);
    chk("sat_busy", bus.busy, 0);

    // reset in RD_DRIVE, then the in-flight cycle is sat out in ABORT
    bus.nce = 1'b0; bus.addr = 2'b10;
    tick(1);
    bus.noe = 1'b0;
    tick(4);
    bus.rd_valid = 1'b1; bus.rd_data = 16'hCAFE;
    tick(1);
    bus.rd_valid = 1'b0; bus.rd_data = '0;
    chk("rr_oe",   bus.data_oe, 1);
    chk("rr_dout", bus.data_out, 16'hCAFE);
    rst = 1'b1;
    tick(1);
    chk("rr_oe_off", bus.data_oe, 0);
    chk("rr_cnt",    bus.err_cnt, 0);
    chk("rr_busy",   bus.busy, 0);
    chk("rr_dout0",  bus.data_out, 0);
    rst = 1'b0;
    tick(4);
    chk("rr_abort", bus.busy, 1);
    chk("rr_no_oe", bus.data_oe, 0);
    chk("rr_rd",    rd_n, 3);
    bus.noe = 1'b1; bus.nce = 1'b1;
    tick(5);
    chk("rr_idle",  bus.busy, 0);
    chk("rr_cnt2",  bus.err_cnt, 0);
    chk("rr_rd2",   rd_n, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fsmc_frontend.md
Name: fsmc_frontend

Overview:
Bus-side front end for the STM32 FSMC slave path. Synchronises the asynchronous FSMC control strobes into the FPGA clock domain and aligns address and data with them. Emits single-cycle write and read request strobes to the buffer/register back end, returns read data to the bus with a controlled output enable, and flags protocol violations. Sits directly upstream of the FSMC buffer/index block, which consumes wr_stb/rd_stb instead of doing its own edge detection.

Parameters:
AW, 2, width of FSMC address bits brought into the FPGA
DW, 16, FSMC data bus width
SYNC, 2, synchroniser depth for noe/nwe/nce (min 2)
FILT, 1, consecutive synchronised-low cycles required before a strobe low is accepted (glitch filter, min 1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
nce  input  1  FSMC chip select for this bank, active-low, async
noe  input  1  FSMC output enable, active-low, async
nwe  input  1  FSMC write enable, active-low, async
addr  input  AW  FSMC address, async
data_in  input  DW  FSMC data bus, input side of pad
data_out  output  DW  data driven to FSMC bus
data_oe  output  1  pad output enable, 1 = drive data_out
wr_stb  output  1  one-cycle write request to back end
wr_addr  output  AW  address qualified by wr_stb
wr_data  output  DW  data qualified by wr_stb
rd_stb  output  1  one-cycle read request to back end
rd_addr  output  AW  address qualified by rd_stb
rd_data  input  DW  back-end read data
rd_valid  input  1  rd_data valid this cycle (any latency ≥1 after rd_stb)
err_pulse  output  1  one-cycle pulse on any protocol error
err_cnt  output  8  saturating protocol error count
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0. data_out = 0, err_cnt = 0, FSM = IDLE. Synchroniser chains preset to all-ones (strobes inactive).
- noe, nwe and nce each pass through SYNC flops. addr and data_in pass through SYNC plain register stages, so they stay cycle-aligned with the synchronised strobes.
- sel = synchronised nce low. "Low accepted" = synchronised strobe low for FILT consecutive cycles, counted by a per-strobe filter counter that clears on any high.
- IDLE:
  - noe and nwe both accepted low with sel -> ABORT, err.
  - nwe accepted low with sel -> WR_ACTIVE.
  - noe accepted low with sel -> RD_WAIT. On the transition cycle, rd_stb = 1 and rd_addr = aligned addr.
- WR_ACTIVE:
  - First cycle synchronised nwe is high -> wr_stb = 1 for one cycle, with wr_addr/wr_data = aligned addr/data_in from that same cycle (values at the nwe rising edge). Then -> IDLE.
  - Synchronised noe low during WR_ACTIVE -> ABORT, err, no wr_stb.
  - sel lost before nwe rises -> IDLE, err, no wr_stb.
- RD_WAIT:
  - rd_valid -> latch rd_data into data_out, -> RD_DRIVE.
  - Synchronised noe high before rd_valid -> IDLE, err. The late rd_valid is ignored and data_out is unchanged.
- RD_DRIVE: data_oe = 1 while synchronised noe low and sel. Synchronised noe high or sel high -> data_oe = 0 in the same cycle as the detection, -> IDLE.
- data_oe is 1 only in RD_DRIVE. It is never 1 while synchronised nwe is low.
- ABORT: stays until synchronised noe, nwe and nce are all high, then -> IDLE. No strobes are issued in ABORT.
- Error handling:
  - err_pulse is high for one cycle on each error event.
  - err_cnt increments by 1 on each event and saturates at 255 with no wrap.
- Strobes and state changes are ignored while nce is high. A cycle that starts without sel issues nothing.
- Latency:
  - wr_stb = SYNC+1 clk after the nwe rising edge at the pin (±1 for metastability).
  - rd_stb = SYNC+FILT clk after the noe falling edge at the pin.
- Back-to-back FSMC cycles are accepted with one idle clk between them minimum.
- rst mid-cycle: returns to IDLE with outputs 0, no strobe issued. Any cycle still in progress at the pins when rst releases is treated as ABORT until all strobes are high.

Test Plan:
- Write: nce=0, addr=2'b10, data_in=16'h1234, nwe low 6 clk then high -> exactly one wr_stb, wr_addr=2, wr_data=16'h1234, SYNC+1 clk after the rise, err_cnt=0.
- Read, rd_valid 2 clk after rd_stb with rd_data=16'hBEEF, noe held low 8 clk -> one rd_stb with rd_addr correct, data_oe=1 with data_out=16'hBEEF until noe rise is detected, then data_oe=0.
- Late read: noe low 3 clk, rd_valid withheld until after the noe rise -> err_pulse once, err_cnt=1, data_oe never 1, data_out unchanged.
- Overlap: noe and nwe low together with nce=0 -> ABORT, err_cnt+1, no wr_stb/rd_stb, return to IDLE only after all three strobes are high.
- Glitch and deselect: FILT=2, a 1-clk noe low pulse -> no rd_stb. A full write with nce=1 -> no wr_stb, no error.
- Saturation and reset: 300 overlap errors -> err_cnt=255. Assert rst during RD_DRIVE -> next clk data_oe=0, err_cnt=0, busy=0.
